// File: rtl/veritune_pkg.sv
// Shared definitions for the audio front end: sample width, FFT frame size,
// and the frame buffer control states.
package veritune_pkg;

   localparam int SAMPLE_W = 16;
   localparam int FFT_N    = 8;

   typedef enum logic [1:0] {
      S_PRIME = 2'd0,
      S_HOP   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/sample_shift_reg.sv
// Eight-entry sample window; each shift moves entries toward w[0] and
// writes the new sample into w[7].
module sample_shift_reg #(
   parameter int SAMPLE_W = 16
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                clear,
   input  logic                shift_en,
   input  logic [SAMPLE_W-1:0] din,
   output logic [SAMPLE_W-1:0] w [0:7]
);

   always_ff @(posedge Clk) begin
      if (!Rst_n || clear) begin
         for (int i = 0; i < 8; i++) w[i] <= '0;
      end else if (shift_en) begin
         for (int i = 0; i < 7; i++) w[i] <= w[i+1];
         w[7] <= din;
      end
   end

endmodule

// File: rtl/sample_frame_buffer.sv
// Collects streamed ADC samples into 8-sample frames for the FFT8 stage,
// with optional 50% overlap (HOP = 4) and a single registered output slot.
module sample_frame_buffer #(
   parameter int SAMPLE_W = veritune_pkg::SAMPLE_W,
   parameter int HOP      = 8
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic [SAMPLE_W-1:0] In_Data,
   input  logic                In_Valid,
   output logic                In_Ready,
   input  logic                Flush,
   output logic [SAMPLE_W-1:0] X0,
   output logic [SAMPLE_W-1:0] X1,
   output logic [SAMPLE_W-1:0] X2,
   output logic [SAMPLE_W-1:0] X3,
   output logic [SAMPLE_W-1:0] X4,
   output logic [SAMPLE_W-1:0] X5,
   output logic [SAMPLE_W-1:0] X6,
   output logic [SAMPLE_W-1:0] X7,
   output logic                Frame_Valid,
   input  logic                Frame_Ready,
   output logic [7:0]          Frame_Cnt
);

   import veritune_pkg::*;

   state_t              state;
   logic [3:0]          cnt;
   logic [3:0]          thr;
   logic [3:0]          cnt_inc;
   logic                accept;
   logic                slot_free;
   logic                shift_en;
   logic [SAMPLE_W-1:0] w [0:FFT_N-1];
   logic [SAMPLE_W-1:0] x [0:FFT_N-1];

   assign In_Ready  = Rst_n && (state != S_FULL);
   assign accept    = In_Valid && In_Ready;
   assign slot_free = !Frame_Valid || Frame_Ready;
   // A flush on the same edge as an accept discards that sample.
   assign shift_en  = accept && !Flush;
   assign thr       = (state == S_PRIME) ? 4'(FFT_N) : 4'(HOP);
   assign cnt_inc   = (cnt >= thr) ? thr : cnt + 4'd1;

   sample_shift_reg #(
      .SAMPLE_W (SAMPLE_W)
   ) u_window (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .clear    (Flush),
      .shift_en (shift_en),
      .din      (In_Data),
      .w        (w)
   );

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state       <= S_PRIME;
         cnt         <= '0;
         Frame_Valid <= 1'b0;
         Frame_Cnt   <= '0;
         for (int i = 0; i < FFT_N; i++) x[i] <= '0;
      end else begin
         if (Frame_Valid && Frame_Ready) Frame_Valid <= 1'b0;
         // Flush never retracts a presented frame; it only drops the window.
         if (Flush) begin
            state <= S_PRIME;
            cnt   <= '0;
         end else begin
            case (state)
               S_PRIME, S_HOP: begin
                  if (accept) begin
                     cnt <= cnt_inc;
                     if (cnt_inc == thr) state <= S_FULL;
                  end
               end
               S_FULL: begin
                  if (slot_free) begin
                     for (int i = 0; i < FFT_N; i++) x[i] <= w[i];
                     Frame_Valid <= 1'b1;
                     Frame_Cnt   <= Frame_Cnt + 8'd1;
                     cnt         <= '0;
                     state       <= S_HOP;
                  end
               end
               default: state <= S_PRIME;
            endcase
         end
      end
   end

   assign X0 = x[0];
   assign X1 = x[1];
   assign X2 = x[2];
   assign X3 = x[3];
   assign X4 = x[4];
   assign X5 = x[5];
   assign X6 = x[6];
   assign X7 = x[7];

endmodule

// File: doc/sample_frame_buffer.md
SAMPLE_FRAME_BUFFER -- requirements
Module: sample_frame_buffer

Interface
REQ-001 Parameter SAMPLE_W, default 16: unsigned audio sample width, range 0-65535.
REQ-002 Parameter HOP, default 8: new samples per frame after the first; legal values 4 (50% overlap) and 8 (no overlap).
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Rst_n  in  1  synchronous, active-low reset, sampled on rising Clk.
REQ-005 In_Data  in  SAMPLE_W  audio sample from the ADC front end.
REQ-006 In_Valid  in  1  In_Data valid this cycle.
REQ-007 In_Ready  out  1  block can accept a sample; transfer occurs when In_Valid and In_Ready are both 1.
REQ-008 Flush  in  1  single-cycle request to discard the partial window and restart priming.
REQ-009 X0..X7  out  SAMPLE_W each  registered 8-sample frame for the FFT8 stage; X0 oldest, X7 newest.
REQ-010 Frame_Valid  out  1  X0..X7 hold a complete frame.
REQ-011 Frame_Ready  in  1  FFT stage consumes the frame when Frame_Valid and Frame_Ready are both 1.
REQ-012 Frame_Cnt  out  8  count of frames presented; wraps 255 -> 0.

Function
REQ-013 Window: 8-entry shift register W; each accepted sample shifts W toward W0 and is written into W7.
REQ-014 Counter cnt counts accepted samples since the last frame transfer; threshold T = 8 in PRIME and T = HOP in HOP.
REQ-015 States: PRIME, entered at reset or Flush, collecting the first 8 samples; HOP, collecting HOP samples; FULL, window complete and waiting for the output slot.
REQ-016 PRIME -> FULL and HOP -> FULL on the edge that accepts the sample making cnt = T.
REQ-017 FULL -> HOP, with cnt cleared, on the edge where the output slot is free, i.e. (not Frame_Valid) or Frame_Ready.
REQ-018 On that same FULL -> HOP edge: X0..X7 load W0..W7, Frame_Valid is set to 1, and Frame_Cnt increments.
REQ-019 In_Ready = 1 iff state is not FULL and Rst_n = 1; no samples are ever dropped.
REQ-020 Latency: if sample k is accepted at edge e and completes the window, Frame_Valid is 1 after edge e+1 when the output slot is free; otherwise it is 1 after the first later edge at which the slot frees.
REQ-021 Frame_Valid clears on a consume handshake unless a FULL -> HOP transfer occurs on the same edge; in that case it stays 1 with new data.
REQ-022 X0..X7 are stable while Frame_Valid = 1 and Frame_Ready = 0.
REQ-023 With HOP = 4, consecutive frames share 4 samples: X0..X3 of frame n+1 equal X4..X7 of frame n.
REQ-024 Flush: next state is PRIME, cnt = 0, W cleared; a frame already presented is not retracted.
REQ-025 Flush and a sample accept on the same edge: Flush wins and the sample is discarded.
REQ-026 Flush while in FULL: the pending window is discarded and no transfer occurs on that edge.
REQ-027 No arithmetic is performed on sample values; cnt is 4 bits wide and saturates at T.

Reset
REQ-028 While Rst_n = 0 at an edge: state = PRIME, cnt = 0, W = 0, X0..X7 = 0, Frame_Valid = 0, Frame_Cnt = 0.
REQ-029 In_Ready = 0 while Rst_n = 0, and 1 in the first cycle after reset is released.
REQ-030 Reset mid-frame discards all samples and any presented frame; priming restarts and requires 8 samples.

Structure
REQ-031 Shared package veritune_pkg holds SAMPLE_W, FFT_N = 8, and the state enumeration {PRIME, HOP, FULL}.
REQ-032 The window shift register is one sub-module, sample_shift_reg, with ports Clk, Rst_n, clear, shift_en, din, and w[0:7].
REQ-033 Control FSM, counter, and output registers reside in sample_frame_buffer.

Verification
REQ-034 HOP = 8: stream samples 1..16 with Frame_Ready = 1.
  - Expect frame 1 = 1..8 and frame 2 = 9..16; Frame_Cnt = 2.
  - Frame_Valid rises 1 cycle after the edge accepting sample 8.
REQ-035 HOP = 4: stream samples 1..12 continuously.
  - Expect frames (1..8), (5..12); Frame_Cnt = 2.
REQ-036 Backpressure: Frame_Ready = 0 after frame 1, HOP = 8, stream 9..20.
  - In_Ready drops after sample 16 is accepted; X holds 1..8 unchanged.
  - On Frame_Ready = 1, frame 9..16 follows in the same edge as the handshake and In_Ready returns to 1.
REQ-037 Flush pulsed together with an accept of sample 5 after samples 1..4.
  - Then stream 100..107.
  - Expect the only frame = 100..107.
REQ-038 Reset asserted after 6 samples while a frame is presented.
  - All outputs read 0 and In_Ready = 0 during reset.
  - After release, 8 fresh samples are required before Frame_Valid.
REQ-039 Boundaries:
  - Samples 0 and 65535 pass through bit-exact.
  - Frame_Cnt wraps 255 -> 0 after the 256th frame.
